// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and size helpers for the byte-enable data memory
package dmem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Error codes kept as a named type so the err field can widen later
    typedef logic err_code_t;
    localparam err_code_t ERR_NONE = 1'b0;
    localparam err_code_t ERR_ADDR = 1'b1;

    function automatic int f_bytes(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int f_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int f_idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - single-port word array with per-byte write enables and registered read
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                      clk,
    input  logic                      rd_en,
    input  logic                      rd_clr,
    input  logic                      we,
    input  logic [DATA_W/8-1:0]       be,
    input  logic [f_idx_w(DEPTH)-1:0] idx,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata
);

    localparam int BYTES = f_bytes(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write; unselected lanes keep their contents
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < BYTES; k++) begin
                if (be[k]) begin
                    mem[idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    // Registered read returns the pre-write word; clear forces zero for reset and rejected reads
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_be_ctrl.sv
// rtl/dmem_be_ctrl.sv - data memory controller with clear sequence, address checks and read strobe
module dmem_be_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd,
    input  logic                wr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                busy,
    output logic                err
);

    localparam int BYTES = f_bytes(DATA_W);
    localparam int OFF_W = f_off_w(DATA_W);
    localparam int IDX_W = f_idx_w(DEPTH);

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  PTR_LAST = IDX_W'(DEPTH - 1);

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  ptr;

    logic              aligned;
    logic              in_range;
    logic              addr_ok;
    logic [IDX_W-1:0]  req_idx;

    logic              bank_rd;
    logic              bank_clr;
    logic              bank_we;
    logic [BYTES-1:0]  bank_be;
    logic [IDX_W-1:0]  bank_idx;
    logic [DATA_W-1:0] bank_wdata;

    // Range check uses the full-width word index so high address bits cannot alias
    assign aligned  = (addr & OFF_MASK) == '0;
    assign in_range = (addr >> OFF_W) < DEPTH_A;
    assign addr_ok  = aligned && in_range;
    assign req_idx  = addr[OFF_W +: IDX_W];
    assign busy     = (state == CLEAR);

    // Next state and bank port steering; the clear walk owns the port while busy
    always_comb begin
        next_state = state;
        bank_rd    = 1'b0;
        bank_clr   = 1'b0;
        bank_we    = 1'b0;
        bank_be    = '0;
        bank_idx   = req_idx;
        bank_wdata = wdata;
        case (state)
            CLEAR: begin
                bank_we    = 1'b1;
                bank_be    = '1;
                bank_idx   = ptr;
                bank_wdata = '0;
                if (ptr == PTR_LAST) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                if (addr_ok) begin
                    bank_rd = rd;
                    bank_we = wr;
                    bank_be = be;
                end else begin
                    bank_clr = rd;
                end
            end
            default: next_state = CLEAR;
        endcase
        if (!reset) begin
            next_state = CLEAR;
            bank_rd    = 1'b0;
            bank_we    = 1'b0;
            bank_clr   = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Clear pointer walks every word once per clear sequence and wraps back to zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + IDX_W'(1);
        end
    end

    // Registered response strobes; rejected reads still complete with rvalid
    always_ff @(posedge clk) begin
        if (!reset) begin
            rvalid <= 1'b0;
            err    <= ERR_NONE;
        end else begin
            rvalid <= (state == IDLE) && rd;
            err    <= ((state == IDLE) && (rd || wr) && !addr_ok) ? ERR_ADDR : ERR_NONE;
        end
    end

    dmem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk    (clk),
        .rd_en  (bank_rd),
        .rd_clr (bank_clr),
        .we     (bank_we),
        .be     (bank_be),
        .idx    (bank_idx),
        .wdata  (bank_wdata),
        .rdata  (rdata)
    );

endmodule

// File: tb/tb_dmem_be_ctrl.sv
// tb/tb_dmem_be_ctrl.sv - scoreboard bench for dmem_be_ctrl with a word-array reference model
module tb_dmem_be_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        busy;
    logic        err;

    dmem_be_ctrl #(
        .DATA_W (32),
        .DEPTH  (256),
        .ADDR_W (32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .be     (be),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          rv;
        logic [31:0] d;
        bit          e;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model[256];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every response the DUT presents must match the oldest expectation and arrive on time
    always @(posedge clk) begin
        exp_t h;
        #2;
        if (rvalid || err) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_resp cyc=%0d rvalid=%0b err=%0b rdata=%h, required no response", cyc, rvalid, err, rdata);
            end else begin
                h = sb.pop_front();
                if (h.due != cyc || rvalid != h.rv || err != h.e || (h.rv && rdata != h.d)) begin
                    n_err++;
                    $display("FAIL resp cyc=%0d got rvalid=%0b err=%0b rdata=%h, required cyc=%0d rvalid=%0b err=%0b rdata=%h",
                             cyc, rvalid, err, rdata, h.due, h.rv, h.e, h.d);
                end
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            h = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_resp cyc=%0d got none, required rvalid=%0b err=%0b rdata=%h", cyc, h.rv, h.e, h.d);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one cycle of request at the falling edge; the model decides the response from the address rules
    task automatic issue(input bit r, input bit w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d, input bit in_clear);
        exp_t        x;
        longint      word;
        bit          ok;
        logic [31:0] mask;
        rd = r; wr = w; be = b; addr = a; wdata = d;
        if (!in_clear && (r || w)) begin
            word = longint'(a) / 4;
            ok   = (a % 4 == 0) && (word < 256);
            x.due = cyc + 1;
            x.rv  = r;
            x.e   = !ok;
            x.d   = (r && ok) ? model[word] : 32'h0;
            if (r || !ok) sb.push_back(x);
            if (w && ok) begin
                mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
                model[word] = (model[word] & ~mask) | (d & mask);
            end
        end
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(0, 0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
    endtask

    // Count busy cycles from the release of reset; a write and a read are thrown at the clear walk
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 400) begin
            n++;
            if (n == 5)      issue(0, 1, 4'hF, 32'h40, 32'hFFFF_FFFF, 1'b1);
            else if (n == 6) issue(1, 0, 4'h0, 32'h40, 32'h0, 1'b1);
            else             @(negedge clk);
        end
    endtask

    initial begin
        int          nb;
        logic [31:0] a;
        int          sel;
        reset = 1'b0; rd = 1'b0; wr = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy",   {31'h0, busy},   32'h1);
        check("reset_rvalid", {31'h0, rvalid}, 32'h0);
        check("reset_err",    {31'h0, err},    32'h0);
        check("reset_rdata",  rdata,           32'h0);
        reset = 1'b1;
        count_busy(nb);
        check("busy_cycles", nb, 256);

        issue(1, 0, 4'h0, 32'h3FC, 32'h0, 1'b0);
        issue(0, 1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0);
        issue(0, 1, 4'h1, 32'h10, 32'h0000_00AA, 1'b0);
        issue(1, 0, 4'h0, 32'h10, 32'h0, 1'b0);
        issue(0, 1, 4'hF, 32'h20, 32'h1111_1111, 1'b0);
        issue(1, 1, 4'hF, 32'h20, 32'h2222_2222, 1'b0);
        issue(1, 0, 4'h0, 32'h20, 32'h0, 1'b0);
        issue(0, 1, 4'hF, 32'h13, 32'h5555_5555, 1'b0);
        issue(1, 0, 4'h0, 32'h400, 32'h0, 1'b0);
        issue(0, 1, 4'h0, 32'h30, 32'h7777_7777, 1'b0);
        issue(1, 0, 4'h0, 32'h30, 32'h0, 1'b0);
        issue(0, 1, 4'hF, 32'h0001_0010, 32'h9999_9999, 1'b0);
        issue(1, 0, 4'h0, 32'h0001_0010, 32'h0, 1'b0);
        issue(1, 0, 4'h0, 32'h10, 32'h0, 1'b0);
        issue(1, 0, 4'h0, 32'h11, 32'h0, 1'b0);
        idle(1);
        check("rdata_hold", rdata, 32'h0);

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            else if (sel == 7) a = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            else if (sel == 8) a = 32'h400 + 32'($urandom_range(0, 4095)) * 4;
            else               a = $urandom;
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, 1'b0);
        end
        idle(3);

        pulse_reset();
        repeat (100) @(negedge clk);
        check("midclear_busy", {31'h0, busy}, 32'h1);
        pulse_reset();
        count_busy(nb);
        check("busy_cycles_again", nb, 256);
        issue(1, 0, 4'h0, 32'h40, 32'h0, 1'b0);
        issue(1, 0, 4'h0, 32'h10, 32'h0, 1'b0);
        issue(1, 0, 4'h0, 32'h3FC, 32'h0, 1'b0);
        idle(3);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_be_ctrl.md
# dmem_be_ctrl

Parametrised data memory for the single-cycle/pipelined CPU datapath, replacing the fixed 32-bit word-only RAM. It adds byte-lane write enables for sb/sh/sw, a registered read port with a valid strobe, and alignment and range error reporting. After reset it also runs a hardware clear sequence that zeroes every word, one word per cycle, under a busy flag. The CPU stalls on `busy` and consumes `rdata` when `rvalid` is high.

## Interface
- `DATA_W`, 32: word width in bits; a multiple of 8, at least 8.
- `DEPTH`, 256: number of words; a power of 2, at least 2.
- `ADDR_W`, 32: byte-address width.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `rd`  in  1: read request.
- `wr`  in  1: write request.
- `be`  in  DATA_W/8: byte-lane write enables; bit k covers `wdata[8k+7:8k]`.
- `addr`  in  ADDR_W: byte address.
- `wdata`  in  DATA_W: write data.
- `rdata`  out  DATA_W: registered read data.
- `rvalid`  out  1: `rdata` is valid this cycle; single-cycle pulse.
- `busy`  out  1: clear sequence in progress; all requests are ignored.
- `err`  out  1: single-cycle pulse; the previous-cycle request was misaligned or out of range.

## Operation
- Derived values:
  - BYTES = DATA_W/8; OFF_W = log2(BYTES).
  - idx = `addr >> OFF_W`; off = `addr[OFF_W-1:0]`.
  - A request is accepted when `rd | wr` is high, `busy` is low, off = 0 and idx < DEPTH.
  - idx is compared at full ADDR_W width, never truncated. High address bits must not alias.
- Reset (reset = 0 at an edge):
  - state goes to CLEAR; clear pointer = 0.
  - busy = 1, rvalid = 0, rdata = 0, err = 0.
  - Memory contents are not written while reset is held.
- CLEAR state:
  - Each edge with reset = 1 writes 0 to word[ptr] and increments ptr.
  - The edge that clears word DEPTH-1 moves the state to IDLE and sets busy = 0.
  - rd and wr are ignored: no write, rvalid = 0, err = 0.
- IDLE state, accepted write:
  - Each byte k of word[idx] with `be[k]` = 1 takes `wdata` byte k.
  - Other bytes keep their value.
  - be = 0 is a legal no-op write and does not raise err.
- IDLE state, accepted read: the next edge loads rdata = word[idx] and sets rvalid = 1.
- rd and wr together at the same idx: read-before-write. rdata returns the old word, and the write still takes effect.
- Rejected request (rd or wr with a misaligned or out-of-range address):
  - No memory write.
  - Next cycle: err = 1. If rd was high, rvalid = 1 and rdata = 0.
- No request (rd = wr = 0):
  - Next cycle: rvalid = 0, err = 0.
  - rdata holds its last value.
- Reset mid-clear or mid-operation returns to CLEAR with ptr = 0 and clears the whole array again.

## Timing
- Read latency is 1 cycle: request at edge N gives rdata/rvalid valid after edge N+1.
- Back-to-back reads are supported every cycle, with full throughput.
- A write is visible to a read issued in the next cycle.
- busy stays high for exactly DEPTH cycles after the first edge with reset = 1.
- The first request can be accepted on the cycle where busy = 0.
- err and rvalid are registered; neither output has a combinational path from the inputs.

## Structure
- Package `dmem_pkg` holds:
  - state enum {CLEAR, IDLE};
  - functions computing BYTES, OFF_W and IDX_W = log2(DEPTH);
  - the shared `ERR_NONE` and `ERR_ADDR` encodings, for later error-code widening.
- Sub-module `dmem_bank`: a plain array with one port, registered read and per-byte write enables. The clear sequence drives this same port, so no reset loop over the array is needed.
- The top level holds the FSM, clear pointer, address decode, and the rvalid/err registers.

## Test plan
All scenarios use DATA_W = 32, DEPTH = 256.
- Reset low 2 cycles, then high: busy = 1 for exactly 256 cycles then 0. A read of addr 0x3FC then returns 0 with rvalid = 1.
- Write 0xDEADBEEF to 0x10 with be = 4'b1111, then write 0x000000AA with be = 4'b0001, then read 0x10 -> rdata = 0xDEADBEAA one cycle after the request.
- rd and wr together at 0x20 (old value 0x11111111, wdata 0x22222222) -> rdata = 0x11111111. A following read returns 0x22222222.
- Write to 0x13 (misaligned) and read 0x400 (out of range) -> err = 1 for one cycle each. The read gives rvalid = 1, rdata = 0. Memory is unchanged.
- Address aliasing: addr 0x0001_0010 -> err, and word 4 is untouched.
- Reset asserted at clear count 100, released -> busy is high for a full 256 cycles again. A write issued during busy is dropped (later read = 0).
